// File: rtl/rf_wb_arbiter_pkg.sv
// Shared constants and types for the register-file writeback arbiter.
package rf_pkg;
   localparam int DATA_W   = 16;
   localparam int ADDR_W   = 4;
   localparam int NUM_REGS = 2 ** ADDR_W;

   typedef enum logic {
      REQ_ALU = 1'b0,
      REQ_LSU = 1'b1
   } req_id_e;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } wr_req_t;
endpackage

// File: rtl/rf_wb_arbiter_if.sv
// One writeback requester's valid/ready channel (destination register + data).
interface rf_wb_arbiter_if #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 4
);
   logic              valid;
   logic              ready;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] data;

   modport master (output valid, addr, data, input ready);
   modport slave  (input valid, addr, data, output ready);
endinterface

// File: rtl/rf_wb_arbiter_rr_arb2.sv
// Two-input arbiter: round-robin on ties, or fixed priority to the load requester.
module rr_arb2
   import rf_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic       prio_mode,
   input  logic [1:0] req,
   output logic [1:0] gnt
);
   req_id_e last_grant_q, last_grant_d;

   always_comb begin
      gnt          = 2'b00;
      last_grant_d = last_grant_q;
      if (en) begin
         case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = (prio_mode || last_grant_q == REQ_ALU) ? 2'b10 : 2'b01;
            default: gnt = 2'b00;
         endcase
      end
      if (gnt[1])
         last_grant_d = REQ_LSU;
      else if (gnt[0])
         last_grant_d = REQ_ALU;
   end

   // Reset to LSU so that the ALU wins the first tie.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         last_grant_q <= REQ_LSU;
      else
         last_grant_q <= last_grant_d;
   end
endmodule

// File: rtl/rf_wb_arbiter.sv
// Writeback arbiter for Register_File's single write port with pending-write scoreboard.
// Optional RF_BYPASS_EN macro enables combinational forwarding of the in-flight write.
module rf_wb_arbiter #(
   parameter int DATA_W    = rf_pkg::DATA_W,
   parameter int ADDR_W    = rf_pkg::ADDR_W,
   parameter bit PRIO_MODE = 1'b0,
   parameter int CNT_W     = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wb_stall,
   rf_wb_arbiter_if.slave    req0,
   rf_wb_arbiter_if.slave    req1,
   input  logic              rsv_valid,
   input  logic [ADDR_W-1:0] rsv_addr,
   input  logic [ADDR_W-1:0] chk_rs,
   input  logic [ADDR_W-1:0] chk_rt,
   output logic              busy_rs,
   output logic              busy_rt,
   output logic              reg_wr,
   output logic [ADDR_W-1:0] reg_file_Rd,
   output logic [DATA_W-1:0] reg_dataWrite,
   output logic              fwd_rs_hit,
   output logic              fwd_rt_hit,
   output logic [DATA_W-1:0] fwd_data,
   output logic              rsv_err,
   output logic [CNT_W-1:0]  contention_cnt
);
   localparam int NUM_REGS = 2 ** ADDR_W;

   logic [1:0]          gnt;
   logic                reg_wr_q, reg_wr_d;
   logic [ADDR_W-1:0]   rd_q, rd_d;
   logic [DATA_W-1:0]   data_q, data_d;
   logic [NUM_REGS-1:0] busy_q, busy_d;
   logic                rsv_err_q, rsv_err_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;

   rr_arb2 u_arb (
      .clk       (clk),
      .rst       (rst),
      .en        (!wb_stall),
      .prio_mode (PRIO_MODE),
      .req       ({req1.valid, req0.valid}),
      .gnt       (gnt)
   );

   assign req0.ready = gnt[0];
   assign req1.ready = gnt[1];

   always_comb begin
      reg_wr_d  = |gnt;
      rd_d      = rd_q;
      data_d    = data_q;
      if (gnt[1]) begin
         rd_d   = req1.addr;
         data_d = req1.data;
      end else if (gnt[0]) begin
         rd_d   = req0.addr;
         data_d = req0.data;
      end

      // Clear first so a same-cycle reservation of the written register wins.
      busy_d = busy_q;
      if (reg_wr_q)
         busy_d[rd_q] = 1'b0;
      if (rsv_valid)
         busy_d[rsv_addr] = 1'b1;

      rsv_err_d = rsv_err_q | (rsv_valid & busy_q[rsv_addr]);

      cnt_d = cnt_q;
      if (req0.valid && req1.valid && cnt_q != {CNT_W{1'b1}})
         cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         reg_wr_q  <= 1'b0;
         rd_q      <= '0;
         data_q    <= '0;
         busy_q    <= '0;
         rsv_err_q <= 1'b0;
         cnt_q     <= '0;
      end else begin
         reg_wr_q  <= reg_wr_d;
         rd_q      <= rd_d;
         data_q    <= data_d;
         busy_q    <= busy_d;
         rsv_err_q <= rsv_err_d;
         cnt_q     <= cnt_d;
      end
   end

   assign reg_wr         = reg_wr_q;
   assign reg_file_Rd    = rd_q;
   assign reg_dataWrite  = data_q;
   assign busy_rs        = busy_q[chk_rs];
   assign busy_rt        = busy_q[chk_rt];
   assign rsv_err        = rsv_err_q;
   assign contention_cnt = cnt_q;

`ifdef RF_BYPASS_EN
   assign fwd_rs_hit = reg_wr_q && (rd_q == chk_rs);
   assign fwd_rt_hit = reg_wr_q && (rd_q == chk_rt);
   assign fwd_data   = data_q;
`else
   assign fwd_rs_hit = 1'b0;
   assign fwd_rt_hit = 1'b0;
   assign fwd_data   = '0;
`endif
endmodule
